// File: rtl/game_motion.sv
// game_motion: per-frame player/enemy motion engine for the renderer.
// Positions update only on the last pixel of each frame (blanking).
module game_motion #(
   parameter int H_TOTAL       = 800,
   parameter int V_TOTAL       = 525,
   parameter int VIS_X_MIN     = 145,
   parameter int OBJ_SIZE      = 60,
   parameter int PLAYER_X      = 200,
   parameter int GROUND_Y      = 400,
   parameter int CEIL_Y        = 50,
   parameter int ENEMY_START_X = 783 - OBJ_SIZE,
   parameter int ENEMY_SPEED   = 4,
   parameter int JUMP_VEL      = 12,
   parameter int GRAVITY       = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] x,
   input  logic [15:0] y,
   input  logic        button,
   input  logic        collision,
   output logic [15:0] x_player,
   output logic [15:0] y_player,
   output logic [15:0] x_enemy,
   output logic [15:0] y_enemy,
   output logic        frame_tick,
   output logic        running,
   output logic [15:0] score
);

   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

   localparam logic [15:0] GND     = 16'(GROUND_Y);
   localparam logic [15:0] CEIL    = 16'(CEIL_Y);
   localparam logic [15:0] E_START = 16'(ENEMY_START_X);
   localparam logic [15:0] E_STEP  = 16'(ENEMY_SPEED);
   localparam logic [15:0] E_WRAP  = 16'(VIS_X_MIN + ENEMY_SPEED);
   localparam logic signed [7:0] V_JUMP = 8'(-JUMP_VEL);
   localparam logic signed [8:0] V_GRAV = 9'(GRAVITY);

   state_t state, state_n;
   logic [2:0] sync;
   logic btn_edge, tick_c, upd, jr;
   logic signed [7:0] vel, vel_n, v0;
   logic signed [8:0] v_inc;
   logic on_ground, on_ground_n, jump_req, jump_req_n;
   logic [15:0] y_sum, y_player_n, x_enemy_n, score_n;

   // button is active-low: a press is a synchronised 1->0 step
   assign btn_edge = sync[2] & ~sync[1];
   assign tick_c   = (x == 16'(H_TOTAL - 1)) && (y == 16'(V_TOTAL - 1));
   assign upd      = (state == RUN) && tick_c && !collision;
   assign x_player = 16'(PLAYER_X);
   assign y_enemy  = GND;

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (btn_edge) state_n = RUN;
         RUN:     if (collision) state_n = HALT;
         HALT:    state_n = HALT;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      jr          = jump_req | btn_edge;
      v0          = (jr && on_ground) ? V_JUMP : vel;
      y_sum       = y_player + {{8{v0[7]}}, v0};
      v_inc       = {v0[7], v0} + V_GRAV;
      vel_n       = vel;
      on_ground_n = on_ground;
      y_player_n  = y_player;
      x_enemy_n   = x_enemy;
      score_n     = score;
      jump_req_n  = jump_req;
      if (state == RUN) jump_req_n = tick_c ? 1'b0 : jr;
      if (upd) begin
         if (v_inc > 9'sd127)       vel_n = 8'sd127;
         else if (v_inc < -9'sd127) vel_n = -8'sd127;
         else                       vel_n = v_inc[7:0];
         if (y_sum >= GND) begin
            y_player_n  = GND;
            vel_n       = '0;
            on_ground_n = 1'b1;
         end else if (y_sum < CEIL) begin
            y_player_n  = CEIL;
            vel_n       = '0;
            on_ground_n = 1'b0;
         end else begin
            y_player_n  = y_sum;
            on_ground_n = 1'b0;
         end
         if (x_enemy < E_WRAP) begin
            x_enemy_n = E_START;
            if (score != 16'hFFFF) score_n = score + 16'd1;
         end else begin
            x_enemy_n = x_enemy - E_STEP;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         sync       <= '0;
         frame_tick <= 1'b0;
         running    <= 1'b0;
         jump_req   <= 1'b0;
         vel        <= '0;
         on_ground  <= 1'b1;
         y_player   <= GND;
         x_enemy    <= E_START;
         score      <= '0;
      end else begin
         state      <= state_n;
         sync       <= {sync[1:0], button};
         frame_tick <= tick_c && (state_n != HALT);
         running    <= (state_n == RUN);
         jump_req   <= jump_req_n;
         vel        <= vel_n;
         on_ground  <= on_ground_n;
         y_player   <= y_player_n;
         x_enemy    <= x_enemy_n;
         score      <= score_n;
      end
   end

endmodule

// File: tb/tb_game_motion.sv
// tb_game_motion: directed + randomized checks of game_motion
// against a frame-level behavioural model.
module tb_game_motion;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] x = '0;
   logic [15:0] y = '0;
   logic        button = 1'b1;
   logic        collision = 1'b0;
   logic [15:0] x_player, y_player, x_enemy, y_enemy, score;
   logic        frame_tick, running;

   int tests = 0;
   int fails = 0;

   int my, mv, mg, mjr, mx, msc, mst;

   game_motion dut (
      .clk(clk), .reset(reset), .x(x), .y(y),
      .button(button), .collision(collision),
      .x_player(x_player), .y_player(y_player),
      .x_enemy(x_enemy), .y_enemy(y_enemy),
      .frame_tick(frame_tick), .running(running), .score(score)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic vis();
      x = 16'($urandom_range(150, 780));
      y = 16'($urandom_range(40, 500));
   endtask

   task automatic model_reset();
      my = 400; mv = 0; mg = 1; mjr = 0;
      mx = 723; msc = 0; mst = 0;
   endtask

   task automatic model_press();
      if (mst == 0) mst = 1;
      else if (mst == 1) mjr = 1;
   endtask

   task automatic model_tick();
      int ny;
      if (mst != 1) return;
      if (mjr != 0 && mg != 0) mv = -12;
      mjr = 0;
      ny = my + mv;
      mv = mv + 1;
      if (mv > 127) mv = 127;
      if (mv < -127) mv = -127;
      if (ny >= 400) begin
         my = 400; mv = 0; mg = 1;
      end else if (ny < 50) begin
         my = 50; mv = 0; mg = 0;
      end else begin
         my = ny; mg = 0;
      end
      if (mx < 149) begin
         mx = 723;
         if (msc < 65535) msc++;
      end else begin
         mx = mx - 4;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".y_player"}, 32'(y_player), 32'(my));
      chk({tag, ".x_enemy"}, 32'(x_enemy), 32'(mx));
      chk({tag, ".score"}, 32'(score), 32'(msc));
      chk({tag, ".running"}, 32'(running), 32'(mst == 1));
      chk({tag, ".x_player"}, 32'(x_player), 32'd200);
      chk({tag, ".y_enemy"}, 32'(y_enemy), 32'd400);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #2;
      model_reset();
      check_all("reset");
      chk("reset.frame_tick", 32'(frame_tick), 32'd0);
      cyc(1);
      reset = 1'b1;
      cyc(1);
   endtask

   task automatic tick();
      x = 16'd799; y = 16'd524;
      cyc(1);
      model_tick();
      chk("frame_tick_hi", 32'(frame_tick), 32'(mst != 2));
      x = '0; y = '0;
      cyc(1);
      chk("frame_tick_lo", 32'(frame_tick), 32'd0);
      vis();
      cyc(1);
      check_all("tick");
   endtask

   task automatic press();
      button = 1'b0;
      cyc(3);
      model_press();
      chk("press.running", 32'(running), 32'(mst == 1));
      cyc(1);
      button = 1'b1;
      cyc(3);
   endtask

   // falling pin timed so the detected edge lands on the tick edge
   task automatic press_on_tick();
      button = 1'b0;
      cyc(2);
      x = 16'd799; y = 16'd524;
      cyc(1);
      model_press();
      model_tick();
      x = '0; y = '0;
      button = 1'b1;
      cyc(3);
      vis();
      cyc(1);
      check_all("press_on_tick");
   endtask

   initial begin
      #1;
      do_reset();

      for (int i = 0; i < 3; i++) tick();
      for (int i = 0; i < 20; i++) begin
         vis();
         cyc(1);
      end
      check_all("idle_vis");

      press();
      tick();
      chk("start.x_enemy", 32'(x_enemy), 32'd719);
      chk("start.y_player", 32'(y_player), 32'd400);

      press();
      for (int t = 1; t <= 25; t++) begin
         tick();
         if (t == 1) chk("jump.t1", 32'(y_player), 32'd388);
         if (t == 5) press();
         if (t == 12) chk("jump.apex", 32'(y_player), 32'd322);
         if (t == 25) chk("jump.land", 32'(y_player), 32'd400);
      end

      do_reset();
      press();
      for (int t = 1; t <= 145; t++) begin
         tick();
         if (t == 144) chk("wrap.t144", 32'(x_enemy), 32'd147);
         if (t == 145) begin
            chk("wrap.t145", 32'(x_enemy), 32'd723);
            chk("wrap.score", 32'(score), 32'd1);
         end
      end

      for (int i = 0; i < 200; i++) begin
         int r;
         r = int'($urandom_range(0, 9));
         if (r < 2) press();
         else if (r == 2) press_on_tick();
         else tick();
      end

      x = 16'd799; y = 16'd524;
      collision = 1'b1;
      cyc(1);
      mst = 2;
      collision = 1'b0;
      x = '0; y = '0;
      cyc(1);
      check_all("halt");
      press();
      tick();
      tick();
      check_all("halt_hold");

      do_reset();
      press();
      press();
      for (int t = 0; t < 5; t++) tick();
      chk("midjump.y", 32'(y_player), 32'd350);
      do_reset();
      press();
      chk("restart.running", 32'(running), 32'd1);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

endmodule
